// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding req/valid fetch,
// and drives the IF/ID pipeline register with stall, redirect, drain and halt handling.
module fetch_stage #(
    parameter int                DATA_W     = 16,
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                PC_STEP    = 2,
    parameter logic [3:0]        HLT_OPCODE = 4'hF
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              imem_valid,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0] ifid_pc_plus,
    output logic              ifid_valid,
    output logic              hlt
);

    typedef enum logic [1:0] {S_REQ, S_HOLD, S_DRAIN, S_HALT} state_t;

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [DATA_W-1:0] ifid_instr_reg, ifid_instr_next;
    logic [ADDR_W-1:0] ifid_pc_plus_reg, ifid_pc_plus_next;
    logic              ifid_valid_reg, ifid_valid_next;
    logic              hlt_reg, hlt_next;
    logic [DATA_W-1:0] buf_reg, buf_next;

    logic [ADDR_W-1:0] pc_plus;
    logic              req_state;
    logic              accept;
    logic [DATA_W-1:0] accept_data;

    assign pc_plus = pc_reg + STEP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= S_REQ;
            pc_reg           <= RESET_PC;
            ifid_instr_reg   <= '0;
            ifid_pc_plus_reg <= '0;
            ifid_valid_reg   <= 1'b0;
            hlt_reg          <= 1'b0;
            buf_reg          <= '0;
        end else begin
            state_reg        <= state_next;
            pc_reg           <= pc_next;
            ifid_instr_reg   <= ifid_instr_next;
            ifid_pc_plus_reg <= ifid_pc_plus_next;
            ifid_valid_reg   <= ifid_valid_next;
            hlt_reg          <= hlt_next;
            buf_reg          <= buf_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        pc_next           = pc_reg;
        ifid_instr_next   = ifid_instr_reg;
        ifid_pc_plus_next = ifid_pc_plus_reg;
        ifid_valid_next   = ifid_valid_reg;
        hlt_next          = hlt_reg;
        buf_next          = buf_reg;
        req_state         = 1'b0;
        accept            = 1'b0;
        accept_data       = imem_rdata;

        case (state_reg)
            S_REQ: begin
                req_state = 1'b1;
                if (imem_valid && !stall) begin
                    accept = 1'b1;
                end else if (imem_valid && stall) begin
                    buf_next   = imem_rdata;
                    state_next = S_HOLD;
                end else if (!stall) begin
                    ifid_valid_next = 1'b0;
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    accept      = 1'b1;
                    accept_data = buf_reg;
                    state_next  = S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem_valid) begin
                    state_next = S_REQ;
                end
            end
            S_HALT: begin
                if (!stall) begin
                    ifid_valid_next = 1'b0;
                end
            end
            default: state_next = S_REQ;
        endcase

        // Shared accept path for a fresh response and a buffered one; halts keep pc on the HLT.
        if (accept) begin
            ifid_instr_next   = accept_data;
            ifid_pc_plus_next = pc_plus;
            ifid_valid_next   = 1'b1;
            if (accept_data[DATA_W-1 -: 4] == HLT_OPCODE) begin
                state_next = S_HALT;
                hlt_next   = 1'b1;
            end else begin
                pc_next = pc_plus;
            end
        end

        // Redirect wins over everything; an unanswered request must still be drained.
        if (branch_taken) begin
            pc_next           = branch_target;
            ifid_instr_next   = ifid_instr_reg;
            ifid_pc_plus_next = ifid_pc_plus_reg;
            ifid_valid_next   = 1'b0;
            hlt_next          = 1'b0;
            buf_next          = buf_reg;
            if ((state_reg == S_REQ || state_reg == S_DRAIN) && !imem_valid) begin
                state_next = S_DRAIN;
            end else begin
                state_next = S_REQ;
            end
        end
    end

    assign imem_req     = req_state & rst_n;
    assign imem_addr    = pc_reg;
    assign pc           = pc_reg;
    assign ifid_instr   = ifid_instr_reg;
    assign ifid_pc_plus = ifid_pc_plus_reg;
    assign ifid_valid   = ifid_valid_reg;
    assign hlt          = hlt_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a variable-latency single-outstanding memory responder.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata = 16'hDEAD;
    logic        imem_valid = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = '0;
    logic [15:0] pc;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc_plus;
    logic        ifid_valid;
    logic        hlt;

    int checks = 0;
    int errors = 0;

    int          lat = 1;
    int          cnt = 0;
    logic        pending = 1'b0;
    logic [15:0] req_addr = '0;

    fetch_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_valid   (imem_valid),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .pc           (pc),
        .ifid_instr   (ifid_instr),
        .ifid_pc_plus (ifid_pc_plus),
        .ifid_valid   (ifid_valid),
        .hlt          (hlt)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h0010) return 16'hF000;
        if (a == 16'h0030) return 16'hA0B0;
        return 16'h1123 + {1'b0, a[15:1]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s = %0h", tag, obs);
        end
    endtask

    // Memory answers the request it latched after lat cycles, even once req has dropped.
    task automatic mem_step();
        imem_valid = 1'b0;
        imem_rdata = 16'hDEAD;
        if (!rst_n) begin
            pending = 1'b0;
            return;
        end
        if (!pending && imem_req) begin
            pending  = 1'b1;
            cnt      = 0;
            req_addr = imem_addr;
        end
        if (pending) begin
            cnt++;
            if (cnt >= lat) begin
                imem_valid = 1'b1;
                imem_rdata = mem_word(req_addr);
                pending    = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        mem_step();
    endtask

    task automatic do_reset(input int latency);
        rst_n        = 1'b0;
        stall        = 1'b0;
        branch_taken = 1'b0;
        lat          = latency;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        mem_step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values with rst_n held low
        tick();
        check("rst_pc", pc, 16'h0000);
        check("rst_req", imem_req, 1'b0);
        check("rst_ifid_valid", ifid_valid, 1'b0);
        check("rst_ifid_instr", ifid_instr, 16'h0000);
        check("rst_hlt", hlt, 1'b0);

        // 1: zero-wait memory, one instruction per cycle
        do_reset(1);
        check("t1_req", imem_req, 1'b1);
        check("t1_addr", imem_addr, 16'h0000);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("t1_valid", ifid_valid, 1'b1);
            check("t1_instr", ifid_instr, 16'h1122 + 16'(k));
            check("t1_pc_plus", ifid_pc_plus, 16'(2 * k));
            check("t1_pc", pc, 16'(2 * k));
        end

        // 2: three-cycle latency, two bubbles between instructions
        do_reset(3);
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 3; j++) begin
                check("t2_req", imem_req, 1'b1);
                check("t2_addr", imem_addr, 16'(2 * k));
                check("t2_pc", pc, 16'(2 * k));
                if (j > 0) check("t2_bubble", ifid_valid, 1'b0);
                tick();
            end
            check("t2_valid", ifid_valid, 1'b1);
            check("t2_instr", ifid_instr, 16'h1123 + 16'(k));
            check("t2_pc_plus", ifid_pc_plus, 16'(2 * k + 2));
        end

        // 3: branch with same-cycle response, then stall over the response
        do_reset(1);
        tick();
        branch_taken  = 1'b1;
        branch_target = 16'h0030;
        tick();
        branch_taken = 1'b0;
        check("t3_br_valid", ifid_valid, 1'b0);
        check("t3_br_addr", imem_addr, 16'h0030);
        stall = 1'b1;
        for (int j = 0; j < 2; j++) begin
            tick();
            check("t3_stall_req", imem_req, 1'b0);
            check("t3_stall_instr", ifid_instr, 16'h1123);
            check("t3_stall_pc", pc, 16'h0030);
        end
        stall = 1'b0;
        tick();
        check("t3_instr", ifid_instr, 16'hA0B0);
        check("t3_valid", ifid_valid, 1'b1);
        check("t3_pc", pc, 16'h0032);
        check("t3_addr", imem_addr, 16'h0032);

        // 4: branch while a request is outstanding drains the wrong-path response
        lat = 3;
        tick();
        check("t4_instr", ifid_instr, 16'h113C);
        branch_taken  = 1'b1;
        branch_target = 16'h0040;
        tick();
        branch_taken = 1'b0;
        check("t4_valid", ifid_valid, 1'b0);
        check("t4_req", imem_req, 1'b0);
        check("t4_pc", pc, 16'h0040);
        tick();
        check("t4_drain_req", imem_req, 1'b0);
        tick();
        check("t4_req2", imem_req, 1'b1);
        check("t4_addr", imem_addr, 16'h0040);
        check("t4_bubble", ifid_valid, 1'b0);
        tick();
        tick();
        tick();
        check("t4_instr2", ifid_instr, 16'h1143);
        check("t4_pc_plus", ifid_pc_plus, 16'h0042);

        // 5: halt at 0x0010, resume via branch
        do_reset(1);
        for (int k = 0; k < 8; k++) tick();
        check("t5_pc_pre", pc, 16'h0010);
        tick();
        check("t5_hlt", hlt, 1'b1);
        check("t5_pc", pc, 16'h0010);
        check("t5_req", imem_req, 1'b0);
        check("t5_instr", ifid_instr, 16'hF000);
        check("t5_valid", ifid_valid, 1'b1);
        tick();
        check("t5_retired", ifid_valid, 1'b0);
        check("t5_hlt_sticky", hlt, 1'b1);
        branch_taken  = 1'b1;
        branch_target = 16'h0020;
        tick();
        branch_taken = 1'b0;
        check("t5_hlt_clr", hlt, 1'b0);
        check("t5_addr", imem_addr, 16'h0020);
        check("t5_req2", imem_req, 1'b1);
        tick();
        check("t5_instr2", ifid_instr, 16'h1133);

        // 6: async reset mid-drain and mid-hold
        do_reset(3);
        branch_taken  = 1'b1;
        branch_target = 16'h0040;
        tick();
        branch_taken = 1'b0;
        check("t6_drain_pc", pc, 16'h0040);
        #2 rst_n = 1'b0;
        #1;
        check("t6_drain_rst_pc", pc, 16'h0000);
        check("t6_drain_rst_req", imem_req, 1'b0);
        do_reset(1);
        tick();
        stall = 1'b1;
        tick();
        check("t6_hold_req", imem_req, 1'b0);
        check("t6_hold_valid", ifid_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_hold_rst_pc", pc, 16'h0000);
        check("t6_hold_rst_valid", ifid_valid, 1'b0);
        check("t6_hold_rst_instr", ifid_instr, 16'h0000);
        check("t6_hold_rst_pc_plus", ifid_pc_plus, 16'h0000);

        // PC wrap from 0xFFFE
        do_reset(1);
        branch_taken  = 1'b1;
        branch_target = 16'hFFFE;
        tick();
        branch_taken = 1'b0;
        check("wrap_addr0", imem_addr, 16'hFFFE);
        tick();
        check("wrap_instr", ifid_instr, 16'h9122);
        check("wrap_pc_plus", ifid_pc_plus, 16'h0000);
        check("wrap_addr1", imem_addr, 16'h0000);
        tick();
        check("wrap_instr2", ifid_instr, 16'h1123);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
